// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback and a long-latency unit (mul/div). Long-latency results wait in a
// small FIFO. The write port is registered.
//
// Configuration macro: WB_ARB_STARVE_EN
//   defined   - a starvation counter forces the FIFO head onto the port after
//               STARVE_LIMIT consecutive pipeline wins. The pipeline is stalled
//               for that cycle.
//   undefined - strict pipeline priority. The FIFO drains only in cycles with
//               no valid pipeline request. pipe_stall_o is tied to 0.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pipe_regwrite_i     pipeline writeback request
//   pipe_rd_add_i       pipeline destination register
//   pipe_data_i         pipeline writeback data
//   pipe_stall_o        combinational; pipeline must hold its writeback
//   lu_valid_i          long-latency result valid
//   lu_ready_o          FIFO not full (derived from registered count)
//   lu_rd_add_i         long-latency destination register
//   lu_data_i           long-latency result data
//   rf_we_o             registered write enable
//   rf_rd_add_o         registered write address
//   rf_data_o           registered write data
//   pend_busy_o         FIFO non-empty (derived from registered count)
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_regwrite_i,
  input  logic [4:0]            pipe_rd_add_i,
  input  logic [DATA_WIDTH-1:0] pipe_data_i,
  output logic                  pipe_stall_o,
  input  logic                  lu_valid_i,
  output logic                  lu_ready_o,
  input  logic [4:0]            lu_rd_add_i,
  input  logic [DATA_WIDTH-1:0] lu_data_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_rd_add_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  pend_busy_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  // Elaboration-time parameter sanity check.
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
    $error("wb_port_arbiter: illegal FIFO_DEPTH or STARVE_LIMIT");
  end

  logic [4:0]            mem_rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  rf_we_d;
  logic [4:0]            rf_rd_add_d;
  logic [DATA_WIDTH-1:0] rf_data_d;

  logic empty, full, push, pipe_req, fifo_grant, pipe_grant;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CntFull);
  assign lu_ready_o  = !full;
  assign pend_busy_o = !empty;
  // Results for x0 are acknowledged but never stored.
  assign push        = lu_valid_i && !full && (lu_rd_add_i != 5'd0);
  // A write to x0 is no request, leaving the port free for the FIFO.
  assign pipe_req    = pipe_regwrite_i && (pipe_rd_add_i != 5'd0);

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       force_fifo;

  // Only registered state feeds force_fifo, so lu_* cannot reach pipe_stall_o.
  assign force_fifo   = !empty && (starve_q == StarveMax);
  assign fifo_grant   = !empty && (force_fifo || !pipe_req);
  assign pipe_grant   = pipe_req && !force_fifo;
  assign pipe_stall_o = force_fifo && pipe_req;

  always_comb begin
    starve_d = starve_q;
    if (empty || fifo_grant) begin
      starve_d = 4'd0;
    end else if (pipe_grant && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fifo_grant   = !empty && !pipe_req;
  assign pipe_grant   = pipe_req;
  assign pipe_stall_o = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_grant ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, fifo_grant})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rf_we_d     = 1'b0;
    rf_rd_add_d = rf_rd_add_o;
    rf_data_d   = rf_data_o;
    if (pipe_grant) begin
      rf_we_d     = 1'b1;
      rf_rd_add_d = pipe_rd_add_i;
      rf_data_d   = pipe_data_i;
    end else if (fifo_grant) begin
      rf_we_d     = 1'b1;
      rf_rd_add_d = mem_rd_q[rd_ptr_q];
      rf_data_d   = mem_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rf_we_o     <= 1'b0;
      rf_rd_add_o <= 5'd0;
      rf_data_o   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rf_we_o     <= rf_we_d;
      rf_rd_add_o <= rf_rd_add_d;
      rf_data_o   <= rf_data_d;
    end
  end

  // Storage needs no reset; the count alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= lu_rd_add_i;
      mem_data_q[wr_ptr_q] <= lu_data_i;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_regwrite_i = 1'b0;
  logic [4:0]  pipe_rd_add_i = '0;
  logic [31:0] pipe_data_i = '0;
  logic        pipe_stall_o;
  logic        lu_valid_i = 1'b0;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_add_i = '0;
  logic [31:0] lu_data_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_rd_add_o;
  logic [31:0] rf_data_o;
  logic        pend_busy_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_WIDTH  (32),
    .FIFO_DEPTH  (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_regwrite_i(pipe_regwrite_i),
    .pipe_rd_add_i  (pipe_rd_add_i),
    .pipe_data_i    (pipe_data_i),
    .pipe_stall_o   (pipe_stall_o),
    .lu_valid_i     (lu_valid_i),
    .lu_ready_o     (lu_ready_o),
    .lu_rd_add_i    (lu_rd_add_i),
    .lu_data_i      (lu_data_i),
    .rf_we_o        (rf_we_o),
    .rf_rd_add_o    (rf_rd_add_o),
    .rf_data_o      (rf_data_o),
    .pend_busy_o    (pend_busy_o)
  );

  typedef struct {
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic pw, input logic [4:0] prd, input logic [31:0] pdata,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                     input logic e_stall, input logic e_we, input logic [4:0] e_rd,
                     input logic [31:0] e_data, input logic e_busy, input logic e_ready);
    vec_t v;
    v = '{pw, prd, pdata, lv, lrd, ldata, e_stall, e_we, e_rd, e_data, e_busy, e_ready};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    pipe_regwrite_i = pw;
    pipe_rd_add_i   = prd;
    pipe_data_i     = pdata;
    lu_valid_i      = lv;
    lu_rd_add_i     = lrd;
    lu_data_i       = ldata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string name, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
    chk({name, ".we"}, 32'(rf_we_o), 32'(we));
    chk({name, ".rd"}, 32'(rf_rd_add_o), 32'(rd));
    chk({name, ".data"}, rf_data_o, data);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.we", 32'(rf_we_o), 32'd0);
    chk("rst.rd", 32'(rf_rd_add_o), 32'd0);
    chk("rst.data", rf_data_o, 32'd0);
    chk("rst.ready", 32'(lu_ready_o), 32'd1);
    chk("rst.busy", 32'(pend_busy_o), 32'd0);
    chk("rst.stall", 32'(pipe_stall_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table, starting from an empty FIFO; never reaches the starve limit.
    //  pw prd  pdata      lv lrd ldata        stall we rd  data         busy ready
    add(1, 5,  32'h1234,  0, 0,  32'h0,       0, 1, 5,  32'h1234,  0, 1);
    add(0, 0,  32'h0,     1, 7,  32'hA5A5,    0, 0, 5,  32'h1234,  1, 1);
    add(0, 0,  32'h0,     0, 0,  32'h0,       0, 1, 7,  32'hA5A5,  0, 1);
    add(0, 0,  32'h0,     0, 0,  32'h0,       0, 0, 7,  32'hA5A5,  0, 1);
    add(1, 0,  32'hDEAD,  1, 3,  32'h33,      0, 0, 7,  32'hA5A5,  1, 1);
    add(1, 0,  32'hBEEF,  0, 0,  32'h0,       0, 1, 3,  32'h33,    0, 1);
    add(0, 0,  32'h0,     1, 0,  32'h77,      0, 0, 3,  32'h33,    0, 1);
    add(1, 12, 32'hC,     1, 4,  32'h44,      0, 1, 12, 32'hC,     1, 1);
    add(1, 13, 32'hD,     1, 0,  32'h99,      0, 1, 13, 32'hD,     1, 1);
    add(0, 0,  32'h0,     0, 0,  32'h0,       0, 1, 4,  32'h44,    0, 1);
    add(1, 1,  32'h1,     1, 6,  32'h66,      0, 1, 1,  32'h1,     1, 1);
    add(0, 0,  32'h0,     1, 8,  32'h88,      0, 1, 6,  32'h66,    1, 1);
    add(0, 0,  32'h0,     0, 0,  32'h0,       0, 1, 8,  32'h88,    0, 1);
    add(1, 2,  32'h2,     1, 10, 32'hAA,      0, 1, 2,  32'h2,     1, 1);
    add(1, 2,  32'h22,    1, 11, 32'hBB,      0, 1, 2,  32'h22,    1, 0);
    add(0, 0,  32'h0,     1, 14, 32'hEE,      0, 1, 10, 32'hAA,    1, 1);
    add(0, 0,  32'h0,     0, 0,  32'h0,       0, 1, 11, 32'hBB,    0, 1);
    add(0, 0,  32'h0,     0, 0,  32'h0,       0, 0, 11, 32'hBB,    0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].pw, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      #1;
      chk($sformatf("v%0d.stall", i), 32'(pipe_stall_o), 32'(vecs[i].e_stall));
      tick();
      chk_port($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data);
      chk($sformatf("v%0d.busy", i), 32'(pend_busy_o), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.ready", i), 32'(lu_ready_o), 32'(vecs[i].e_ready));
    end

    // Starvation: FIFO holds rd=9 under continuous pipeline writes.
    drive(1, 20, 32'h100, 1, 9, 32'h999);
    #1;
    chk("st0.stall", 32'(pipe_stall_o), 32'd0);
    tick();
    chk_port("st0", 1, 20, 32'h100);
    chk("st0.busy", 32'(pend_busy_o), 32'd1);
`ifdef WB_ARB_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(21 + i), 32'h200 + 32'(i), 0, 0, 32'h0);
      #1;
      chk($sformatf("st%0d.stall", i + 1), 32'(pipe_stall_o), 32'd0);
      tick();
      chk_port($sformatf("st%0d", i + 1), 1, 5'(21 + i), 32'h200 + 32'(i));
    end
    drive(1, 25, 32'h300, 0, 0, 32'h0);
    #1;
    chk("st_force.stall", 32'(pipe_stall_o), 32'd1);
    tick();
    chk_port("st_force", 1, 9, 32'h999);
    chk("st_force.busy", 32'(pend_busy_o), 32'd0);
    chk("st_held.stall", 32'(pipe_stall_o), 32'd0);
    tick();
    chk_port("st_held", 1, 25, 32'h300);
`else
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(21 + i), 32'h200 + 32'(i), 0, 0, 32'h0);
      #1;
      chk($sformatf("prio%0d.stall", i), 32'(pipe_stall_o), 32'd0);
      tick();
      chk_port($sformatf("prio%0d", i), 1, 5'(21 + i), 32'h200 + 32'(i));
      chk($sformatf("prio%0d.busy", i), 32'(pend_busy_o), 32'd1);
    end
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    chk_port("prio_drain", 1, 9, 32'h999);
    chk("prio_drain.busy", 32'(pend_busy_o), 32'd0);
`endif
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    chk("st_end.we", 32'(rf_we_o), 32'd0);

    // Backpressure: three back-to-back results with pipeline traffic.
    drive(1, 15, 32'hF0, 1, 16, 32'h16);
    #1;
    chk("bp1.stall", 32'(pipe_stall_o), 32'd0);
    tick();
    chk("bp1.ready", 32'(lu_ready_o), 32'd1);
    drive(1, 15, 32'hF1, 1, 17, 32'h17);
    #1;
    chk("bp2.stall", 32'(pipe_stall_o), 32'd0);
    tick();
    chk("bp2.ready", 32'(lu_ready_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 15, 32'hF2 + 32'(i), 1, 18, 32'h18);
      #1;
      chk($sformatf("bp_hold%0d.stall", i), 32'(pipe_stall_o), 32'd0);
      tick();
      chk_port($sformatf("bp_hold%0d", i), 1, 15, 32'hF2 + 32'(i));
      chk($sformatf("bp_hold%0d.ready", i), 32'(lu_ready_o), 32'd0);
    end
    drive(0, 0, 32'h0, 1, 18, 32'h18);
    tick();
    chk_port("bp_pop1", 1, 16, 32'h16);
    chk("bp_pop1.ready", 32'(lu_ready_o), 32'd1);
    tick();
    chk_port("bp_pop2", 1, 17, 32'h17);
    chk("bp_pop2.busy", 32'(pend_busy_o), 32'd1);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    chk_port("bp_pop3", 1, 18, 32'h18);
    chk("bp_pop3.busy", 32'(pend_busy_o), 32'd0);

    // Async reset with two entries pending and a write on the port.
    drive(1, 26, 32'h260, 1, 27, 32'h27);
    tick();
    drive(1, 26, 32'h261, 1, 28, 32'h28);
    tick();
    chk("ar_pre.we", 32'(rf_we_o), 32'd1);
    chk("ar_pre.ready", 32'(lu_ready_o), 32'd0);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_port("ar_now", 0, 0, 32'h0);
    chk("ar_now.busy", 32'(pend_busy_o), 32'd0);
    chk("ar_now.ready", 32'(lu_ready_o), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar_post%0d.we", i), 32'(rf_we_o), 32'd0);
      chk($sformatf("ar_post%0d.busy", i), 32'(pend_busy_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
